// File: rtl/ecap5_dproc_pkg.sv
// rtl/ecap5_dproc_pkg.sv - shared addresses and types for the instruction fetch path
package ecap5_dproc_pkg;

    localparam logic [31:0] BOOT_ADDRESS      = 32'h0000_0000;
    localparam logic [31:0] INTERRUPT_ADDRESS = 32'h0000_0800;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STALLED
    } issue_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - first-word-fall-through queue of fetched {pc, instr} entries
module prefetch_fifo
    import ecap5_dproc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           data_i,
    input  logic                   pop_i,
    output fetch_entry_t           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_push;
    logic         do_pop;

    // The extra pointer bit tells full from empty when the indices coincide.
    assign count_o = wr_q - rd_q;
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem[rd_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_q[AW-1:0]] <= data_i;
                wr_q              <= wr_q + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - pipelined Wishbone instruction prefetcher with flush on branch/irq
module prefetch_unit
    import ecap5_dproc_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i,
    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW+1:0] DEPTH_C = (CW + 2)'(DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

    issue_state_t  state_q;
    logic [31:0]   adr_q;
    logic [31:0]   fetch_pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic          cyc_q;
    logic [31:0]   trk_mem [MAX_OUTSTANDING];
    logic [TW-1:0] trk_wr_q;
    logic [TW-1:0] trk_rd_q;

    logic          stb;
    logic          accepted;
    logic          flush;
    logic          hold;
    logic          issue_nxt;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard_nxt;
    logic [CW+1:0] credit_used;
    logic [31:0]   fetch_pc_nxt;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    assign stb          = (state_q != IDLE);
    assign accepted     = stb && !wb_stall_i;
    assign flush        = irq_i || branch_i;
    assign hold         = stb && wb_stall_i && !flush;
    assign outstanding_nxt = outstanding_q + CW'(accepted) - CW'(wb_ack_i);

    // Every slot that a queued word, an in-flight read or the read being accepted
    // now could occupy is reserved, so an ack can never find the queue full.
    assign credit_used  = (CW + 2)'(fifo_count) + (CW + 2)'(outstanding_q) + (CW + 2)'(accepted);
    assign issue_nxt    = !flush && (!stb || accepted) && (credit_used < DEPTH_C)
                          && (outstanding_nxt < MAX_C);

    always_comb begin
        fetch_pc_nxt = fetch_pc_q;
        discard_nxt  = discard_q;
        if (flush) begin
            fetch_pc_nxt = irq_i ? INTERRUPT_ADDRESS : branch_target_i;
            discard_nxt  = outstanding_nxt;
        end else begin
            if (accepted) begin
                fetch_pc_nxt = fetch_pc_q + 32'd4;
            end
            if (wb_ack_i && (discard_q != '0)) begin
                discard_nxt = discard_q - CW'(1);
            end
        end
    end

    assign fifo_push        = wb_ack_i && (discard_q == '0) && !flush;
    assign fifo_pop         = !fifo_empty && output_ready_i && !flush;
    assign push_entry.pc    = trk_mem[trk_rd_q];
    assign push_entry.instr = wb_dat_i;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            adr_q         <= '0;
            fetch_pc_q    <= BOOT_ADDRESS;
            outstanding_q <= '0;
            discard_q     <= '0;
            cyc_q         <= 1'b0;
            trk_wr_q      <= '0;
            trk_rd_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_nxt;
            outstanding_q <= outstanding_nxt;
            discard_q     <= discard_nxt;
            cyc_q         <= hold || issue_nxt || (outstanding_nxt != '0) || (discard_nxt != '0);
            case (state_q)
                IDLE: begin
                    if (issue_nxt) begin
                        state_q <= ISSUE;
                        adr_q   <= fetch_pc_nxt;
                    end
                end
                default: begin
                    if (hold) begin
                        state_q <= STALLED;
                    end else if (issue_nxt) begin
                        state_q <= ISSUE;
                        adr_q   <= fetch_pc_nxt;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
            // Acks return in issue order, so the tracker is a plain ring that
            // discarded acks drain just like kept ones.
            if (accepted) begin
                trk_mem[trk_wr_q] <= adr_q;
                trk_wr_q          <= trk_inc(trk_wr_q);
            end
            if (wb_ack_i) begin
                trk_rd_q <= trk_inc(trk_rd_q);
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_push && fifo_full && !fifo_pop));

    assign wb_adr_o       = adr_q;
    assign wb_stb_o       = stb;
    assign wb_cyc_o       = cyc_q;
    assign wb_we_o        = 1'b0;
    assign wb_sel_o       = 4'hF;
    assign output_valid_o = !fifo_empty;
    assign instr_o        = head.instr;
    assign pc_o           = head.pc;

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - self-checking bench for prefetch_unit against a stream-level model
module tb_prefetch_unit;
    import ecap5_dproc_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        irq_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_cyc_o;
    logic        wb_stall_i = 1'b0;
    logic        output_ready_i = 1'b0;
    logic        output_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    always #5 clk_i = ~clk_i;

    prefetch_unit #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .irq_i           (irq_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .wb_adr_o        (wb_adr_o),
        .wb_dat_i        (wb_dat_i),
        .wb_we_o         (wb_we_o),
        .wb_sel_o        (wb_sel_o),
        .wb_stb_o        (wb_stb_o),
        .wb_ack_i        (wb_ack_i),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stall_i      (wb_stall_i),
        .output_ready_i  (output_ready_i),
        .output_valid_o  (output_valid_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o)
    );

    typedef struct {
        logic        irq;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
    } flush_vec_t;

    flush_vec_t  fv [5];
    int          n_vec = 0;
    int          n_miss = 0;
    int          ack_pct = 100;
    int          stall_pct = 0;
    int          rdy_pct = 100;
    logic        stall_force = 1'b0;
    logic        req_irq = 1'b0;
    logic        req_br = 1'b0;
    logic [31:0] req_tgt = '0;
    logic        flush_prev = 1'b0;
    logic [31:0] pend [$];
    logic [31:0] popped [$];
    logic [31:0] acc_log [$];
    logic [31:0] exp_issue = BOOT_ADDRESS;
    logic [31:0] exp_pc = BOOT_ADDRESS;
    int          n_pop = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: slave response, model update for the coming edge, then advance to the next negedge.
    task automatic step();
        logic flush;
        if (rst_ni && flush_prev) begin
            chk("flush_valid_low", 32'(output_valid_o), 0);
            chk("flush_stb_low", 32'(wb_stb_o), 0);
        end
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        if (pend.size() != 0 && int'($urandom_range(0, 99)) < ack_pct) begin
            wb_ack_i = 1'b1;
            wb_dat_i = word_at(pend.pop_front());
        end
        wb_stall_i      = stall_force || (int'($urandom_range(0, 99)) < stall_pct);
        output_ready_i  = int'($urandom_range(0, 99)) < rdy_pct;
        irq_i           = req_irq;
        branch_i        = req_br;
        branch_target_i = req_tgt;
        flush           = req_irq || req_br;
        if (rst_ni) begin
            if (wb_stb_o && !wb_stall_i) begin
                chk("issue_adr", wb_adr_o, exp_issue);
                pend.push_back(wb_adr_o);
                acc_log.push_back(wb_adr_o);
                exp_issue += 32'd4;
                chk("outstanding_le_max", 32'(pend.size() <= MAXO), 1);
            end
            if (output_valid_o && output_ready_i && !flush) begin
                chk("out_pc", pc_o, exp_pc);
                chk("out_instr", instr_o, word_at(exp_pc));
                popped.push_back(pc_o);
                exp_pc += 32'd4;
                n_pop++;
            end
            if (flush) begin
                exp_pc    = req_irq ? INTERRUPT_ADDRESS : req_tgt;
                exp_issue = exp_pc;
            end
        end
        flush_prev = rst_ni && flush;
        req_irq    = 1'b0;
        req_br     = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic restart();
        rst_ni = 1'b0;
        repeat (2) step();
        pend.delete();
        exp_issue  = BOOT_ADDRESS;
        exp_pc     = BOOT_ADDRESS;
        flush_prev = 1'b0;
        rst_ni     = 1'b1;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!output_valid_o && k < 40) begin
            step();
            k++;
        end
        if (!output_valid_o) chk("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        int p0;
        int a0;
        int cnt;
        fv[0] = '{irq: 1'b0, br: 1'b1, tgt: 32'h0000_0100, exp_pc: 32'h0000_0100};
        fv[1] = '{irq: 1'b1, br: 1'b1, tgt: 32'h0000_0200, exp_pc: INTERRUPT_ADDRESS};
        fv[2] = '{irq: 1'b1, br: 1'b0, tgt: 32'h0000_0300, exp_pc: INTERRUPT_ADDRESS};
        fv[3] = '{irq: 1'b0, br: 1'b1, tgt: 32'h0000_01F0, exp_pc: 32'h0000_01F0};
        fv[4] = '{irq: 1'b0, br: 1'b1, tgt: 32'h0000_0000, exp_pc: 32'h0000_0000};

        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (3) step();
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_stb", 32'(wb_stb_o), 0);
        chk("rst_cyc", 32'(wb_cyc_o), 0);
        chk("rst_valid", 32'(output_valid_o), 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_we", 32'(wb_we_o), 0);
        chk("rst_sel", 32'(wb_sel_o), 32'hF);
        pend.delete();
        rst_ni = 1'b1;
        step();
        chk("first_stb", 32'(wb_stb_o), 1);
        chk("first_adr", wb_adr_o, BOOT_ADDRESS);

        // Zero-wait slave, decode always ready: one word per cycle once filled.
        repeat (8) step();
        p0 = n_pop;
        repeat (10) step();
        chk("throughput", 32'(n_pop - p0), 10);

        // Decode not ready: credits stop issue after DEPTH requests.
        rdy_pct = 0;
        restart();
        a0 = acc_log.size();
        repeat (12) step();
        chk("fill_requests", 32'(acc_log.size() - a0), 4);
        chk("fill_stb_low", 32'(wb_stb_o), 0);
        chk("fill_valid", 32'(output_valid_o), 1);
        chk("fill_head_pc", pc_o, 32'h0);
        popped.delete();
        a0 = acc_log.size();
        rdy_pct = 100;
        repeat (8) step();
        chk("drain_count", 32'(popped.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            if (i < popped.size()) chk("drain_pc", popped[i], 32'(i * 4));
        end
        chk("resume_issued", 32'(acc_log.size() > a0), 1);
        if (acc_log.size() > a0) chk("resume_adr", acc_log[a0], 32'h10);

        // Second request stalled for five cycles.
        restart();
        a0 = acc_log.size();
        step();
        step();
        stall_force = 1'b1;
        repeat (5) begin
            step();
            chk("stall_adr", wb_adr_o, 32'h4);
            chk("stall_stb", 32'(wb_stb_o), 1);
        end
        stall_force = 1'b0;
        repeat (6) step();
        cnt = 0;
        for (int i = a0; i < acc_log.size(); i++) begin
            if (acc_log[i] == 32'h4) cnt++;
        end
        chk("stall_single_issue", 32'(cnt), 1);

        // Flush vectors taken with MAX_OUTSTANDING reads in flight.
        for (int i = 0; i < 5; i++) begin
            ack_pct = 0;
            repeat (6) step();
            chk("hold_outstanding", 32'(pend.size()), MAXO);
            req_irq = fv[i].irq;
            req_br  = fv[i].br;
            req_tgt = fv[i].tgt;
            step();
            chk("flush_n1_valid", 32'(output_valid_o), 0);
            ack_pct = 100;
            wait_valid();
            chk("flush_first_pc", pc_o, fv[i].exp_pc);
            chk("flush_first_instr", instr_o, word_at(fv[i].exp_pc));
        end

        // Back-to-back flushes: the later target wins.
        req_br  = 1'b1;
        req_tgt = 32'h500;
        step();
        req_br  = 1'b1;
        req_tgt = 32'h600;
        step();
        wait_valid();
        chk("b2b_first_pc", pc_o, 32'h600);

        // Reset in the middle of a burst while the slave keeps acking.
        repeat (5) step();
        rst_ni = 1'b0;
        step();
        chk("midrst_cyc", 32'(wb_cyc_o), 0);
        chk("midrst_valid", 32'(output_valid_o), 0);
        chk("midrst_stb", 32'(wb_stb_o), 0);
        step();
        pend.delete();
        exp_issue  = BOOT_ADDRESS;
        exp_pc     = BOOT_ADDRESS;
        flush_prev = 1'b0;
        rst_ni     = 1'b1;
        step();
        chk("midrst_first_stb", 32'(wb_stb_o), 1);
        chk("midrst_first_adr", wb_adr_o, BOOT_ADDRESS);

        // Random slave latency, stalls, backpressure and flushes.
        ack_pct   = 60;
        stall_pct = 30;
        rdy_pct   = 70;
        p0 = n_pop;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                req_irq = ($urandom_range(0, 3) == 0);
                req_br  = !req_irq || ($urandom_range(0, 1) == 1);
                req_tgt = 32'($urandom_range(0, 1023)) << 2;
            end
            step();
        end
        chk("random_progress", 32'((n_pop - p0) > 200), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
